// File: rtl/uart_tx_path_pkg.sv
// Shared definitions for the buffered UART transmit path: baud divider math,
// serializer state encoding and 8N1 line levels.
package uart_tx_path_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] OS_LAST    = 4'(OVERSAMPLE - 1);

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Clock cycles per oversampling tick.
  function automatic int calc_div(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx_path_if.sv
// Core-side bus of the UART transmit path: push strobe, byte, line and status.
// writeFlag is a one-cycle push strobe with no ready; txFull is the only
// back-pressure, and a push presented while txFull=1 is dropped (txOverflow).
interface uart_tx_path_if #(
    parameter int DBIT = 8
);
    logic            writeFlag;
    logic [DBIT-1:0] dataToSend;
    logic            tx;
    logic            txFull;
    logic            txEmpty;
    logic            txBusy;
    logic            txOverflow;
    logic            uart_tx_done;

    modport master (
        output writeFlag, dataToSend,
        input  tx, txFull, txEmpty, txBusy, txOverflow, uart_tx_done
    );

    modport slave (
        input  writeFlag, dataToSend,
        output tx, txFull, txEmpty, txBusy, txOverflow, uart_tx_done
    );
endinterface

// File: rtl/uart_tx_path_tx_fifo_buffer.sv
// Synchronous FIFO with registered full/empty flags and an occupancy count.
// Pushes while full and pops while empty are ignored.
module tx_fifo_buffer #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_n;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_n = count;
        case ({push_ok, pop_ok})
            2'b10:   count_n = count + (AW+1)'(1);
            2'b01:   count_n = count - (AW+1)'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            full  <= (count_n == (AW+1)'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_path.sv
// Buffered UART transmitter: FIFO of pushed bytes serialized as 8N1 frames,
// timed by a free-running 16x oversampling tick. All outputs are registered.
module uart_tx_path
    import uart_tx_path_pkg::*;
#(
    parameter int BaudRate = 1200,
    parameter int clk_Mhz  = 60,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int FIFO_AW  = 4
) (
    input  logic              clk,
    input  logic              uart_reset,
    uart_tx_path_if.slave     bus,
    output tx_state_t         dbg_state,
    output logic [FIFO_AW:0]  dbg_fifo_count
);
    localparam int               DIV       = calc_div(clk_Mhz, BaudRate);
    localparam int               DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam int               NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0]    N_LAST    = NW'(DBIT - 1);
    localparam logic [3:0]       STOP_LAST = 4'(SB_TICK - 1);

    logic [DIV_W-1:0] b_cnt;
    logic             tick;

    // Free-running: frames are never resynchronized to the tick phase.
    always_ff @(posedge clk) begin
        if (uart_reset || tick) b_cnt <= '0;
        else                    b_cnt <= b_cnt + DIV_W'(1);
    end
    assign tick = (b_cnt == DIV_LAST);

    logic            fifo_pop;
    logic [DBIT-1:0] fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;

    tx_fifo_buffer #(
        .DW (DBIT),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (uart_reset),
        .push  (bus.writeFlag),
        .pop   (fifo_pop),
        .din   (bus.dataToSend),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (dbg_fifo_count)
    );

    tx_state_t       state, state_n;
    logic [3:0]      s_cnt, s_cnt_n;
    logic [NW-1:0]   n_cnt, n_cnt_n;
    logic [DBIT-1:0] shreg, shreg_n;
    logic            tx_q, tx_n;
    logic            busy_q;
    logic            done_q, done_n;
    logic            ovf_q;

    always_ff @(posedge clk) begin
        if (uart_reset) begin
            state  <= ST_IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            shreg  <= '0;
            tx_q   <= LINE_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_n;
            s_cnt  <= s_cnt_n;
            n_cnt  <= n_cnt_n;
            shreg  <= shreg_n;
            tx_q   <= tx_n;
            busy_q <= (state_n != ST_IDLE);
            done_q <= done_n;
            ovf_q  <= ovf_q | (bus.writeFlag & fifo_full);
        end
    end

    always_comb begin
        state_n  = state;
        s_cnt_n  = s_cnt;
        n_cnt_n  = n_cnt;
        shreg_n  = shreg;
        fifo_pop = 1'b0;
        done_n   = 1'b0;
        tx_n     = LINE_IDLE;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_n  = fifo_dout;
                    s_cnt_n  = '0;
                    state_n  = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_cnt_n = '0;
                        n_cnt_n = '0;
                        state_n = ST_DATA;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt == OS_LAST) begin
                        shreg_n = shreg >> 1;
                        s_cnt_n = '0;
                        if (n_cnt == N_LAST) state_n = ST_STOP;
                        else                 n_cnt_n = n_cnt + NW'(1);
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_cnt == STOP_LAST) begin
                        done_n  = 1'b1;
                        s_cnt_n = '0;
                        state_n = ST_IDLE;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Line level follows the state being entered so tx stays registered.
        case (state_n)
            ST_START: tx_n = START_BIT;
            ST_DATA:  tx_n = shreg_n[0];
            ST_STOP:  tx_n = STOP_BIT;
            default:  tx_n = LINE_IDLE;
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.txFull       = fifo_full;
    assign bus.txEmpty      = fifo_empty;
    assign bus.txBusy       = busy_q;
    assign bus.txOverflow   = ovf_q;
    assign bus.uart_tx_done = done_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_uart_tx_path.sv
// Self-checking bench for uart_tx_path, run with a 4-cycle baud tick so whole
// frames (640 cycles) fit in a short simulation.
module tb_uart_tx_path;
  import uart_tx_path_pkg::*;

  localparam int TB_BAUD    = 15625;
  localparam int TB_CLK_MHZ = 1;
  localparam int DIV        = 4;            // 1e6 / (15625 * 16)
  localparam int BIT        = 16 * DIV;     // cycles per data bit
  localparam int FRAME      = 10 * BIT;     // nominal fall-to-done length

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic uart_reset;
  always #5 clk = ~clk;

  uart_tx_path_if #(.DBIT(8)) bus ();
  tx_state_t  dbg_state;
  logic [4:0] dbg_fifo_count;

  uart_tx_path #(
    .BaudRate (TB_BAUD),
    .clk_Mhz  (TB_CLK_MHZ),
    .DBIT     (8),
    .SB_TICK  (16),
    .FIFO_AW  (4)
  ) dut (
    .clk            (clk),
    .uart_reset     (uart_reset),
    .bus            (bus.slave),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic push(input logic [7:0] b, input bit keep);
    bus.writeFlag  = 1'b1;
    bus.dataToSend = b;
    if (keep) exp_q.push_back(b);
    @(posedge clk); #1;
    bus.writeFlag  = 1'b0;
    bus.dataToSend = 8'($urandom_range(0, 255));
  endtask

  task automatic apply_reset();
    uart_reset = 1'b1;
    @(posedge clk); #1;
    uart_reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.uart_tx_done) break;
    end
    check("done_seen", bus.uart_tx_done, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(posedge clk); #1;
      idle = (exp_q.size() == 0) && bus.txEmpty && !bus.txBusy;
    end
    check("idle_reached", idle, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- done pulse counter ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.uart_tx_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- frame monitor ----------------
  initial begin
    int c;
    logic [7:0] b;
    logic stop_b;
    bit abort;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (uart_reset || bus.tx !== 1'b0) continue;
      b = '0; stop_b = 1'b0; abort = 1'b0;
      for (c = 1; c <= FRAME + 60; c++) begin
        @(negedge clk);
        if (uart_reset) begin abort = 1'b1; break; end
        for (int k = 0; k < 8; k++)
          if (c == BIT * (k + 1) + BIT / 2 - 2) b[k] = bus.tx;
        if (c == BIT * 9 + BIT / 2 - 2) stop_b = bus.tx;
        if (c > BIT * 9 + BIT / 2 - 2 && bus.uart_tx_done) break;
      end
      if (!abort) begin
        check("stop_bit", stop_b, 1);
        check_range("frame_len", c, FRAME - DIV, FRAME + DIV);
        check("frame_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("frame_byte", b, exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 150_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    bus.writeFlag  = 1'b0;
    bus.dataToSend = '0;
    uart_reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1 uart_reset = 1'b0;
    mon_en = 1'b1;

    // Reset values
    check("rst_tx", bus.tx, 1);
    check("rst_full", bus.txFull, 0);
    check("rst_empty", bus.txEmpty, 1);
    check("rst_busy", bus.txBusy, 0);
    check("rst_ovf", bus.txOverflow, 0);
    check("rst_done", bus.uart_tx_done, 0);
    check("rst_state", dbg_state, ST_IDLE);
    repeat (5) @(posedge clk); #1;

    // Single byte: latency and LSB-first 1,0,1,0,0,1,0,1
    base = done_cnt;
    push(8'hA5, 1);
    check("lat_empty_fall", bus.txEmpty, 0);
    check("lat_tx_high", bus.tx, 1);
    @(posedge clk); #1;
    check("lat_tx_fall", bus.tx, 0);
    check("lat_busy", bus.txBusy, 1);
    check("lat_state", dbg_state, ST_START);
    wait_idle(FRAME + 200);
    check("a5_done_cnt", done_cnt - base, 1);
    check("a5_empty", bus.txEmpty, 1);
    check("a5_busy", bus.txBusy, 0);

    // Three back-to-back frames with a one-cycle idle gap
    base = done_cnt;
    push(8'h00, 1);
    push(8'hFF, 1);
    push(8'h55, 1);
    for (int k = 0; k < 3; k++) begin
      wait_done(FRAME + 200);
      if (k < 2) begin
        check("gap_tx_high", bus.tx, 1);
        @(posedge clk); #1;
        check("gap_tx_fall", bus.tx, 0);
      end
    end
    wait_idle(FRAME + 200);
    check("b2b_done_cnt", done_cnt - base, 3);

    // Fill to 16 while the first byte is in flight, then one dropped push
    base = done_cnt;
    push(8'h10, 1);
    for (int k = 1; k <= 16; k++) push(8'(8'h10 + k), 1);
    check("fill_full", bus.txFull, 1);
    check("fill_count", dbg_fifo_count, 16);
    check("fill_ovf_pre", bus.txOverflow, 0);
    push(8'hDE, 0);
    check("fill_ovf", bus.txOverflow, 1);
    check("fill_count_hold", dbg_fifo_count, 16);
    wait_idle(18 * (FRAME + 20));
    check("fill_done_cnt", done_cnt - base, 17);
    check("ovf_sticky", bus.txOverflow, 1);

    // Push while full in the same cycle as the FSM pop
    apply_reset();
    check("ovf_cleared", bus.txOverflow, 0);
    base = done_cnt;
    push(8'h60, 1);
    for (int k = 1; k <= 16; k++) push(8'(8'h60 + 3 * k), 1);
    wait_done(FRAME + 200);
    check("pp_full", bus.txFull, 1);
    check("pp_state", dbg_state, ST_IDLE);
    push(8'hEE, 0);
    check("pp_ovf", bus.txOverflow, 1);
    check("pp_count", dbg_fifo_count, 15);
    check("pp_not_full", bus.txFull, 0);
    wait_idle(17 * (FRAME + 20));
    check("pp_done_cnt", done_cnt - base, 17);

    // Reset during data bit 3 of 0x3C with another byte still queued
    base = done_cnt;
    push(8'h3C, 0);
    push(8'h99, 0);
    repeat (300) @(posedge clk);
    #1;
    check("mid_state", dbg_state, ST_DATA);
    apply_reset();
    check("mid_tx", bus.tx, 1);
    check("mid_empty", bus.txEmpty, 1);
    check("mid_count", dbg_fifo_count, 0);
    check("mid_busy", bus.txBusy, 0);
    check("mid_done", bus.uart_tx_done, 0);
    repeat (FRAME + 60) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt - base, 0);
    check("mid_tx_idle", bus.tx, 1);
    push(8'h81, 1);
    wait_idle(FRAME + 200);
    check("fresh_done_cnt", done_cnt - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_path.md
# uart_tx_path

Buffered UART transmit path: accepts bytes from the core through a write strobe, queues them in a small FIFO, and serializes each one onto `tx` as an 8N1 frame timed by an internal 16x-oversampling baud tick. It is the transmit-side counterpart of the buffered UART receive path and sits between the processor/debug logic and the board TX pin. Frames go out back-to-back while the FIFO holds data; each completed frame is reported with a one-cycle pulse.

## Interface
- `BaudRate`, 1200: line baud rate.
- `clk_Mhz`, 60: clock frequency in MHz.
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: stop-bit length in oversampling ticks.
- `FIFO_AW`, 4: FIFO address width; depth is 2^FIFO_AW, 16 by default.
- `clk`  in  1  single clock for the whole block.
- `uart_reset`  in  1  reset, synchronous and active-high.
- `writeFlag`  in  1  push strobe; 1 cycle = 1 byte.
- `dataToSend`  in  DBIT  byte to push; sampled when `writeFlag`=1.
- `tx`  out  1  serial line, idle high.
- `txFull`  out  1  FIFO full.
- `txEmpty`  out  1  FIFO empty.
- `txBusy`  out  1  serializer not in IDLE.
- `txOverflow`  out  1  sticky flag: a push was dropped.
- `uart_tx_done`  out  1  one-cycle pulse at end of each stop bit.

## Operation
- Baud tick: counter `0..DIV-1`, `DIV = clk_Mhz*1_000_000/(BaudRate*16)` (3125 by default). The tick is a 1-cycle pulse when the counter is `DIV-1`. The counter free-runs and is not resynchronized to frames.
- FIFO:
  - A push is accepted iff `writeFlag && !txFull`.
  - A push while full is dropped and sets `txOverflow`. This holds even if a pop occurs in the same cycle.
  - A pop is issued only by the FSM and only when `!txEmpty`.
  - A simultaneous accepted push and pop leaves the count unchanged.
  - Pointers wrap modulo 2^FIFO_AW. Full/empty are derived from a (FIFO_AW+1)-bit count.
- FSM states: IDLE, START, DATA, STOP. `s_cnt` is 4 bits and counts ticks; `n_cnt` counts bits.
  - IDLE: `tx`=1. If `!txEmpty`: pop, load the shift register with the head byte, clear `s_cnt`, go to START.
  - START: `tx`=0. On a tick, if `s_cnt`=15, clear `s_cnt` and `n_cnt` and go to DATA; otherwise `s_cnt++`.
  - DATA: `tx`=shreg[0], LSB first. On a tick with `s_cnt`=15, shift right and clear `s_cnt`. If `n_cnt`=DBIT-1 go to STOP, else `n_cnt++`.
  - STOP: `tx`=1. On a tick with `s_cnt`=SB_TICK-1, pulse `uart_tx_done` and go to IDLE.
- `txBusy` = (state != IDLE).
- `dataToSend` changing after the push cycle has no effect on the queued byte.

## Timing
- Reset values: `tx`=1, `txFull`=0, `txEmpty`=1, `txBusy`=0, `txOverflow`=0, `uart_tx_done`=0. Baud counter, FIFO pointers and count are 0; state is IDLE.
- All outputs are registered.
- Latency with an empty FIFO and the FSM idle:
  - push at cycle N;
  - `txEmpty` falls at N+1;
  - the pop happens at N+1;
  - `tx` falls at N+2.
- Start-bit width: ends on the 16th tick after entering START, so 15*DIV+1 to 16*DIV cycles. Each data bit and the stop bit are exactly 16*DIV and SB_TICK*DIV cycles.
- Back-to-back frames: STOP→IDLE at cycle M (with the `uart_tx_done` pulse). With the FIFO non-empty, the pop happens at M+1 and `tx` falls at M+2. Idle gap = 1 cycle.
- Reset mid-frame: on the next edge `tx`=1, the FIFO is cleared and the FSM is IDLE. No `uart_tx_done` pulse. The partial frame is lost.
- `txOverflow` clears only on reset.

## Structure
- Shared package: the `DIV` computation, the FSM state encoding, and the 8N1 frame constants.
- One sub-module, `tx_fifo_buffer`: a parameterized synchronous FIFO with push/pop/full/empty/count.
- The baud tick counter and the serializer FSM stay in `uart_tx_path`.

## Test plan
- Reset, then push 0xA5 once. `tx` falls 2 cycles later. Bits sampled at mid-bit read 1,0,1,0,0,1,0,1, then stop=1. One `uart_tx_done` pulse. Then `txEmpty`=1 and `txBusy`=0.
- Push 0x00, 0xFF, 0x55 on consecutive cycles. Three contiguous frames with a 1-cycle idle gap between them. Exactly 3 done pulses. Decoded bytes match in order.
- Push 17 bytes while the FSM is stalled (first byte already popped) plus 1 extra. `txFull`=1 at 16 entries. The extra byte is dropped and `txOverflow`=1. The 16 queued bytes plus the first are transmitted intact.
- When full, assert `writeFlag` in the same cycle as the FSM's pop. The push is dropped, `txOverflow` sets, and the count drops by 1.
- Assert `uart_reset` during DATA bit 3 of 0x3C. `tx`=1 the next cycle, FIFO empty, no done pulse. A fresh push of 0x81 then transmits correctly.
- Frame duration check at defaults: falling edge to done pulse = 160 ticks (10*16) = 500000 cycles ±DIV.
